// File: rtl/tx_arbiter.sv
// ---------------------------------------------------------------------------
// tx_arbiter
//   Two-requester round-robin arbiter in front of a single serial transmitter.
//   The winner's data word is latched, a one-cycle start pulse is issued, and
//   the arbiter waits for tx_done before pulsing the winner's done line.
//   All outputs are registered from the current state, so each one becomes
//   visible one clock after the state that produces it.
//
// Parameters
//   WIDTH    transmit data word width
//   TIMEOUT  WAIT-state cycle limit before abort (1..255), used only when
//            the macro TX_TIMEOUT_EN is defined
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous, active-low
//   req_a, req_b     level requests, held until the matching done pulse
//   data_a, data_b   requester words, sampled in LOAD
//   tx_done          transmitter finished (level or pulse)
//   gnt_a, gnt_b     one-hot grant, LOAD through WAIT
//   tx_start         one-cycle start pulse to the transmitter
//   tx_data          registered word to the transmitter
//   done_a, done_b   one-cycle completion pulse to the winner
//   busy             state is not IDLE
//   timeout          one-cycle abort pulse (constant 0 without TX_TIMEOUT_EN)
//
// Optional feature macro: TX_TIMEOUT_EN (WAIT-state abort counter)
// ---------------------------------------------------------------------------
module tx_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             tx_done,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  output logic             done_a,
  output logic             done_b,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             winner_b_q, winner_b_d;   // 1 when B owns the current transfer
  logic             last_b_q, last_b_d;       // 1 when B was served last
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             tx_start_q, tx_start_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             in_xfer;
  logic             aborted;                  // current transfer ended by timeout

`ifdef TX_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
  logic       timed_out_q, timed_out_d;
  assign aborted = timed_out_q;
`else
  localparam logic [7:0] timeout_limit_unused = 8'(TIMEOUT);
  assign aborted = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    winner_b_d = winner_b_q;
    last_b_d   = last_b_q;
    tx_data_d  = tx_data_q;
`ifdef TX_TIMEOUT_EN
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          // B wins alone, or on a tie when A was served last.
          winner_b_d = req_b && (!req_a || !last_b_q);
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        last_b_d  = winner_b_q;
        tx_data_d = winner_b_q ? data_b : data_a;
        state_d   = S_START;
      end
      S_START: begin
        // tx_done is deliberately ignored here.
        state_d = S_WAIT;
`ifdef TX_TIMEOUT_EN
        cnt_d       = 8'd0;
        timed_out_d = 1'b0;
`endif
      end
      S_WAIT: begin
        // tx_done takes priority over an expiring counter.
        if (tx_done) begin
          state_d = S_DONE;
        end
`ifdef TX_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CNT) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Moore outputs, registered from the present state.
    in_xfer    = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_WAIT);
    gnt_a_d    = in_xfer && !winner_b_q;
    gnt_b_d    = in_xfer && winner_b_q;
    tx_start_d = (state_q == S_START);
    done_a_d   = (state_q == S_DONE) && !aborted && !winner_b_q;
    done_b_d   = (state_q == S_DONE) && !aborted && winner_b_q;
    timeout_d  = (state_q == S_DONE) && aborted;
    busy_d     = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      winner_b_q <= 1'b0;
      last_b_q   <= 1'b1;     // A preferred for the first tie
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef TX_TIMEOUT_EN
      cnt_q       <= 8'd0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      winner_b_q <= winner_b_d;
      last_b_q   <= last_b_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_a_q   <= done_a_d;
      done_b_q   <= done_b_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
`ifdef TX_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign done_a   = done_a_q;
  assign done_b   = done_b_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_arbiter
//   Directed bench for tx_arbiter. Expected transfers (winner, word) are
//   pushed to a scoreboard queue when requests are driven and popped when
//   the arbiter grants. Outputs are sampled 1 time unit after each rising
//   edge. Builds with or without TX_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_tx_arbiter;

  localparam int W  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_a, req_b;
  logic [W-1:0] data_a, data_b;
  logic         tx_done;
  logic         gnt_a, gnt_b, tx_start, done_a, done_b, busy, timeout;
  logic [W-1:0] tx_data;

  typedef struct packed {
    logic         b;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  tx_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .tx_done  (tx_done),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done_a   (done_a),
    .done_b   (done_b),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // One full transfer: wait for grant, check start/data, hold tx_done low for
  // k WAIT cycles, pulse tx_done, check the done pulse goes to the winner.
  task automatic xfer(input int k, input int exp_lat, input bit drop_b,
                      input bit raise_a, input logic [W-1:0] a_word);
    exp_t e;
    int   n;
    n = 0;
    while (!(gnt_a || gnt_b) && n < 20) begin
      tick();
      n++;
    end
    check("gnt_seen", 32'(gnt_a | gnt_b), 1);
    if (exp_lat >= 0) check("gnt_latency", n, exp_lat);
    check("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("gnt_a", gnt_a, !e.b);
    check("gnt_b", gnt_b, e.b);
    check("busy_xfer", busy, 1);
    check("start_early", tx_start, 0);
    tick();
    check("tx_start", tx_start, 1);
    check("tx_data", tx_data, e.data);
    check("gnt_onehot", 32'(gnt_a & gnt_b), 0);
    if (drop_b) req_b = 1'b0;
    if (raise_a) begin
      req_a  = 1'b1;
      data_a = a_word;
      sb.push_back('{b: 1'b0, data: a_word});
    end
    for (int i = 0; i < k; i++) begin
      tick();
      check("start_once", tx_start, 0);
      check("gnt_hold", 32'({gnt_a, gnt_b}), 32'({!e.b, e.b}));
      check("no_early_done", 32'({done_a, done_b, timeout}), 0);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_wait", 32'({done_a, done_b}), 0);
    check("gnt_before_done", 32'({gnt_a, gnt_b}), 32'({!e.b, e.b}));
    tick();
    check("done_a", done_a, !e.b);
    check("done_b", done_b, e.b);
    check("gnt_drop", 32'({gnt_a, gnt_b}), 0);
    check("no_timeout", timeout, 0);
    $display("xfer winner=%s data=%02h wait=%0d", e.b ? "B" : "A", e.data, k);
  endtask

  initial begin
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; tx_done = 1'b0;
    data_a = '0; data_b = '0;

    // Reset state.
    tick(); tick();
    check("rst_outs", 32'({gnt_a, gnt_b, tx_start, done_a, done_b, busy, timeout}), 0);
    check("rst_data", tx_data, 0);
    reset = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Single requester A, word A5, three WAIT cycles.
    req_a = 1'b1; data_a = 8'hA5;
    sb.push_back('{b: 1'b0, data: 8'hA5});
    xfer(3, 2, 1'b0, 1'b0, 8'h00);
    req_a = 1'b0;
    tick();
    check("busy_after_a", busy, 0);
    check("idle_gnt", 32'({gnt_a, gnt_b}), 0);

    // Both requesting from reset: A, B, A, B with a one-cycle gap.
    reset = 1'b0; req_a = 1'b1; req_b = 1'b1; data_a = 8'h3C; data_b = 8'hC3;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{b: i[0], data: i[0] ? 8'hC3 : 8'h3C});
    for (int i = 0; i < 4; i++) xfer(2, 2, 1'b0, 1'b0, 8'h00);
    req_a = 1'b0; req_b = 1'b0;
    tick();
    check("busy_after_rr", busy, 0);

    // B alone drops its request in WAIT; A arrives while B is busy.
    req_b = 1'b1; data_b = 8'h5E;
    sb.push_back('{b: 1'b1, data: 8'h5E});
    xfer(2, 2, 1'b1, 1'b1, 8'h77);
    xfer(1, 2, 1'b0, 1'b0, 8'h00);
    req_a = 1'b0;
    tick();
    check("busy_after_drop", busy, 0);

    // Reset in WAIT with A winning, B pending; A must still win afterwards.
    req_a = 1'b1; data_a = 8'h11;
    tick(); tick(); tick(); tick();
    check("abort_pre_wait", 32'({gnt_a, busy}), 32'b11);
    req_b = 1'b1; data_b = 8'h22;
    reset = 1'b0;
    tick();
    check("abort_outs", 32'({gnt_a, gnt_b, tx_start, done_a, done_b, busy, timeout}), 0);
    check("abort_data", tx_data, 0);
    reset = 1'b1;
    tick();
    check("abort_no_pulse", 32'({done_a, done_b, timeout}), 0);
    sb.push_back('{b: 1'b0, data: 8'h11});
    sb.push_back('{b: 1'b1, data: 8'h22});
    xfer(1, 1, 1'b0, 1'b0, 8'h00);
    xfer(1, 2, 1'b0, 1'b0, 8'h00);
    req_a = 1'b0; req_b = 1'b0;
    tick();

`ifdef TX_TIMEOUT_EN
    // tx_done never comes: counter expires, timeout pulses, no done.
    begin
      int n;
      req_a = 1'b1; data_a = 8'h5A;
      tick(); tick();
      check("to_gnt", gnt_a, 1);
      tick();
      check("to_start", tx_start, 1);
      n = 0;
      while (!timeout && n < 30) begin
        tick();
        n++;
        check("to_no_done", 32'({done_a, done_b}), 0);
      end
      check("to_pulse", timeout, 1);
      // WAIT entered with count 0; abort on the cycle count reaches TO,
      // seen one clock later on the registered output.
      check("to_latency", n, TO + 2);
      check("to_gnt_drop", gnt_a, 0);
      req_a = 1'b0;
      tick();
      check("to_one_cycle", timeout, 0);
    end
`else
    // Without the timeout feature WAIT persists for 100 cycles.
    req_a = 1'b1; data_a = 8'h5A;
    sb.push_back('{b: 1'b0, data: 8'h5A});
    xfer(100, 2, 1'b0, 1'b0, 8'h00);
    req_a = 1'b0;
    tick();
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter WIDTH, 8, width of transmit data word.
REQ-002 Parameter TIMEOUT, 255, WAIT-state cycle limit before abort (1..255); used only with TX_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 req_a  input  1  requester A (memory read/write flow) wants the transmitter; level, held until done_a.
REQ-006 req_b  input  1  requester B (result path) wants the transmitter; level, held until done_b.
REQ-007 data_a  input  WIDTH  A's word, sampled in LOAD.
REQ-008 data_b  input  WIDTH  B's word, sampled in LOAD.
REQ-009 tx_done  input  1  serial transmitter finished current word; level or pulse.
REQ-010 gnt_a, gnt_b  output  1 each  one-hot grant, high from LOAD through WAIT.
REQ-011 tx_start  output  1  one-cycle start pulse to transmitter.
REQ-012 tx_data  output  WIDTH  registered word to transmitter, stable from START until the next LOAD.
REQ-013 done_a, done_b  output  1 each  one-cycle completion pulse to the winning requester.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 timeout  output  1  one-cycle abort pulse; constant 0 without TX_TIMEOUT_EN.

Function
REQ-016 FSM states: IDLE, LOAD, START, WAIT, DONE; registered outputs, Moore style.
REQ-017 IDLE: with no request, stay; with req_a or req_b, select the winner and go to LOAD.
REQ-018 Arbitration: single requester wins; if both, the requester not served last wins (round-robin pointer last_b).
REQ-019 Pointer last_b updates in LOAD only: 1 if B won, 0 if A won.
REQ-020 LOAD: assert winner's gnt; latch winner's data into tx_data; go to START.
REQ-021 START: tx_start=1 for exactly one cycle; go to WAIT; tx_done ignored here.
REQ-022 WAIT: hold gnt; on tx_done=1, go to DONE.
REQ-023 DONE: gnt low; winner's done pulse=1 for one cycle; go to IDLE.
REQ-024 Latency: request first seen at edge n; gnt high after n+1; tx_start high after n+2; done one cycle after tx_done is seen in WAIT.
REQ-025 Minimum gap: one IDLE cycle between DONE and the next LOAD, even with requests still pending.
REQ-026 A requester dropping req after LOAD does not abort the transfer; done still pulses.
REQ-027 req changes of the non-winner while busy have no effect until IDLE.
REQ-028 gnt_a and gnt_b never high together; tx_start never high outside START.

Reset
REQ-029 With reset=0 at a rising edge: state=IDLE; gnt_a, gnt_b, tx_start, done_a, done_b, busy, timeout=0; tx_data=0; last_b=1 (A preferred first); timeout counter=0.
REQ-030 Reset mid-transfer (any state) aborts immediately with no done or timeout pulse.

Configuration
REQ-031 Macro TX_TIMEOUT_EN defined: 8-bit counter clears on entry to WAIT and increments each WAIT cycle without tx_done; at count==TIMEOUT, go to DONE with timeout=1 and no done pulse.
REQ-032 tx_done and count==TIMEOUT in the same cycle: tx_done wins, normal done, no timeout.
REQ-033 Macro TX_TIMEOUT_EN undefined: no counter; WAIT lasts until tx_done; timeout tied 0.

Verification
REQ-034 req_a=1 only, data_a=8'hA5, tx_done after 3 WAIT cycles -> gnt_a at n+1, tx_start with tx_data=A5 at n+2, done_a one pulse, busy low after DONE.
REQ-035 req_a=req_b=1 held from reset, each tx_done after 2 cycles -> grants alternate A,B,A,B; never both grants high.
REQ-036 req_b=1, drop req_b during WAIT -> transfer completes, done_b pulses, return to IDLE.
REQ-037 TX_TIMEOUT_EN, TIMEOUT=4, tx_done held 0 -> timeout pulse after 4 WAIT cycles, no done_a, grant dropped; without macro, WAIT persists 100 cycles.
REQ-038 reset=0 asserted during WAIT -> next edge all outputs 0, no done pulse; next request goes to A even if both requesting.
